// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int          BUF_DEPTH_DEF = 2;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch unit; master is the fetch unit.
interface if_fetch_unit_if;

  logic        enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    input  enable, imem_rdata, redirect_valid, redirect_pc, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );

  modport slave (
    output enable, imem_rdata, redirect_valid, redirect_pc, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
  );

endinterface

// File: rtl/if_buffer.sv
// Small circular FIFO of {pc, instr} entries with push, pop, clear and occupancy count.
module if_buffer
  import if_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 push_entry,
  output entry_t                 head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push    = push && (count != CW'(DEPTH));
  assign do_pop     = pop && (count != '0);
  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push && !clear && !reset) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Clear shares the reset path so a redirect drops everything in one edge.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, handles redirects and
// buffers returned instructions for the decode stage.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
  input logic             clock,
  input logic             reset,
  if_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   inflight_pc_q;
  logic          inflight_q;
  logic          req;
  logic [CW-1:0] count;
  entry_t        head_entry;
  entry_t        push_entry;
  logic          has_head;
  logic          do_pop;
  logic          do_push;
  logic          room;
  logic [31:0]   head_pc;

  assign has_head   = (count != '0);
  assign do_pop     = has_head && bus.out_ready;
  assign do_push    = inflight_q && !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  // A pop this cycle frees a slot, which keeps one fetch per cycle flowing while draining.
  assign room = (count + CW'(inflight_q)) < (CW'(BUF_DEPTH) + CW'(do_pop));

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_RUN;
      S_RUN:   if (!bus.enable) state_d = S_IDLE;
      S_FLUSH: state_d = bus.enable ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.redirect_valid) begin
      state_d = S_FLUSH;
    end
    if ((state_q == S_RUN || state_q == S_FLUSH) && bus.enable &&
        !bus.redirect_valid && !reset && room) begin
      req = 1'b1;
    end
  end

  // A redirect kills the outstanding response simply by dropping the in-flight flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.redirect_valid) begin
        fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= req;
        if (req) begin
          inflight_pc_q <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + PC_INC;
        end
      end
    end
  end

  if_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (do_push),
    .pop        (do_pop),
    .clear      (bus.redirect_valid),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

  assign head_pc          = has_head ? head_entry.pc : '0;
  assign bus.imem_req     = req;
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = has_head;
  assign bus.out_pc       = head_pc;
  assign bus.out_instr    = has_head ? head_entry.instr : '0;
  assign bus.out_pc_plus4 = head_pc + PC_INC;

endmodule
